// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM: sequences PC load, fetch, decode, execute and PC update,
// counts retired instructions and traps halt / fetch-timeout into terminal states.
module pc_sequencer #(
   parameter int FETCH_TIMEOUT = 15,
   parameter int COUNT_W       = 16
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               input_start,
   input  logic               input_mem_ready,
   input  logic               input_dec_branch,
   input  logic               input_dec_jump,
   input  logic               input_dec_halt,
   input  logic               input_exec_done,
   input  logic               input_br_taken,
   output logic               output_PCWrite,
   output logic [1:0]         output_PCSrc,
   output logic               output_IRWrite,
   output logic               output_MemReq,
   output logic [2:0]         output_state,
   output logic               output_halted,
   output logic [COUNT_W-1:0] output_instr_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOADVEC = 3'd1,
      S_FETCH   = 3'd2,
      S_DECODE  = 3'd3,
      S_EXEC    = 3'd4,
      S_UPDATE  = 3'd5,
      S_HALT    = 3'd6,
      S_FAULT   = 3'd7
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

   state_t               state_q, state_d;
   logic [7:0]           tmo_q, tmo_d;
   logic                 jump_f_q, jump_f_d;
   logic                 branch_f_q, branch_f_d;
   logic                 taken_f_q, taken_f_d;
   logic [COUNT_W-1:0]   cnt_q, cnt_d;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_IDLE;
         tmo_q      <= '0;
         jump_f_q   <= 1'b0;
         branch_f_q <= 1'b0;
         taken_f_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         tmo_q      <= tmo_d;
         jump_f_q   <= jump_f_d;
         branch_f_q <= branch_f_d;
         taken_f_q  <= taken_f_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      jump_f_d   = jump_f_q;
      branch_f_d = branch_f_q;
      taken_f_d  = taken_f_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE:    if (input_start) state_d = S_LOADVEC;
         S_LOADVEC: state_d = S_FETCH;
         S_FETCH: begin
            if (input_mem_ready) begin
               tmo_d   = '0;
               state_d = S_DECODE;
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_FAULT;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         S_DECODE: begin
            jump_f_d   = input_dec_jump;
            branch_f_d = input_dec_branch;
            // Halt wins over jump/branch and never retires.
            state_d    = input_dec_halt ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            if (input_exec_done) begin
               taken_f_d = branch_f_q & input_br_taken;
               state_d   = S_UPDATE;
            end
         end
         S_UPDATE: begin
            cnt_d   = cnt_q + COUNT_W'(1);
            state_d = S_FETCH;
         end
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      output_PCWrite = 1'b0;
      output_PCSrc   = 2'b00;
      output_MemReq  = 1'b0;
      output_halted  = 1'b0;
      case (state_q)
         S_LOADVEC: begin
            output_PCWrite = 1'b1;
            output_PCSrc   = 2'b11;
         end
         S_FETCH:  output_MemReq = 1'b1;
         S_UPDATE: begin
            output_PCWrite = 1'b1;
            if (jump_f_q)       output_PCSrc = 2'b10;
            else if (taken_f_q) output_PCSrc = 2'b01;
            else                output_PCSrc = 2'b00;
         end
         S_HALT, S_FAULT: output_halted = 1'b1;
         default: ;
      endcase
   end

   assign output_IRWrite     = (state_q == S_FETCH) & input_mem_ready;
   assign output_state       = state_q;
   assign output_instr_count = cnt_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control FSM that sequences the 16-bit program counter register through fetch, decode, execute and PC update. It drives the PC's write enable and the next-PC source mux select, the instruction-register write and the instruction-memory request. It also retires instructions, counts them, and detects halt and fetch-timeout faults. It sits between the decoder/ALU status signals and the PC, IR and instruction memory.

Parameters:
FETCH_TIMEOUT, 15, maximum consecutive FETCH cycles without mem_ready before entering FAULT (1..255).
COUNT_W, 16, width of the retired-instruction counter.

Ports:
CLK  input  1  clock; all state changes on the rising edge.
RST_N  input  1  reset, asynchronous, active-low.
input_start  input  1  begin execution; sampled only in IDLE.
input_mem_ready  input  1  instruction memory has valid data this cycle.
input_dec_branch  input  1  decoded instruction is a conditional branch.
input_dec_jump  input  1  decoded instruction is a jump.
input_dec_halt  input  1  decoded instruction is halt.
input_exec_done  input  1  execute phase complete this cycle.
input_br_taken  input  1  branch condition; valid when exec_done=1.
output_PCWrite  output  1  PC write enable.
output_PCSrc  output  2  next-PC select: 00 = PC+2, 01 = branch target, 10 = jump target, 11 = reset vector.
output_IRWrite  output  1  instruction register write enable.
output_MemReq  output  1  instruction fetch request.
output_state  output  3  current state encoding.
output_halted  output  1  1 in HALT or FAULT.
output_instr_count  output  COUNT_W  retired-instruction count.

Behaviour:
- States: IDLE=0, LOADVEC=1, FETCH=2, DECODE=3, EXEC=4, UPDATE=5, HALT=6, FAULT=7.
- Outputs are a Moore decode of the state register, except IRWrite, which is combinational (FETCH & mem_ready).
- Reset (RST_N=0, asynchronous):
  - State=IDLE; instr_count=0; timeout counter=0; latched flags=0.
  - All outputs 0, including PCSrc=00.
  - Takes effect immediately, mid-operation included; no PCWrite is issued while reset is held.
- IDLE: all outputs 0. start=1 -> LOADVEC; otherwise stay.
- LOADVEC: one cycle; PCWrite=1, PCSrc=11 -> FETCH.
- FETCH:
  - MemReq=1.
  - mem_ready=1: IRWrite=1 the same cycle; timeout counter cleared; -> DECODE.
  - mem_ready=0: timeout counter increments. When the counter already equals FETCH_TIMEOUT-1 -> FAULT.
  - With FETCH_TIMEOUT=15, the 15th consecutive not-ready cycle moves to FAULT.
- DECODE: one cycle.
  - Latches jump_f=dec_jump and branch_f=dec_branch.
  - dec_halt=1 -> HALT. Halt has priority over jump/branch and does not increment instr_count.
  - Otherwise -> EXEC.
- EXEC:
  - Waits for exec_done; no enables asserted.
  - On exec_done=1: latches taken_f = branch_f & br_taken; -> UPDATE.
  - No timeout in EXEC.
- UPDATE: one cycle; PCWrite=1.
  - PCSrc = 10 if jump_f; else 01 if taken_f; else 00. Jump wins over branch when both are decoded.
  - instr_count increments, wrapping modulo 2^COUNT_W.
  - -> FETCH.
- HALT and FAULT:
  - halted=1; all enables 0.
  - Terminal: only reset exits; start is ignored.
- start is ignored in every state except IDLE. Decoder inputs are ignored outside DECODE; br_taken is ignored unless EXEC & exec_done.
- PCWrite is never asserted in two consecutive cycles. Minimum instruction latency (fetch ready immediately, exec_done immediately) is 4 cycles: FETCH, DECODE, EXEC, UPDATE.

Test Plan:
- Reset then start=1, mem_ready and exec_done tied 1, no branch/jump/halt -> state sequence 0,1,2,3,4,5,2…
  - PCWrite high in LOADVEC (PCSrc=11) and in every UPDATE (PCSrc=00).
  - instr_count=3 after three UPDATE cycles.
- Branch decoded:
  - br_taken=1 at exec_done -> UPDATE PCSrc=01.
  - Repeat with br_taken=0 -> PCSrc=00.
  - dec_jump=1 and dec_branch=1 with br_taken=1 -> PCSrc=10.
- mem_ready held 0 for 14 cycles then 1 -> no fault; IRWrite pulses once; DECODE follows. Held 0 for 15 cycles -> state=7, halted=1, MemReq=0.
- dec_halt=1 in DECODE -> state=6, halted=1, instr_count unchanged. start and mem_ready toggling afterwards -> no change.
- RST_N asserted during EXEC with exec_done=1 -> asynchronous return to IDLE with no PCWrite pulse; instr_count=0. Restart requires start.
- COUNT_W=4: 16 retired instructions -> instr_count wraps 15 -> 0.
